// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_AW_DEFAULT = 6;

  // Which port owns the read data returning this cycle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    D    = 2'd2
  } rsel_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side signals of the arbiter.
// master = requesters plus memory model, slave = the arbiter itself.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
);

  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              m_en;
  logic              m_we;
  logic [MEM_AW-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive cycles the fetch port loses to the data port;
// flags starvation once the count reaches STARVE_MAX.
module mem_arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic starve
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt || !if_req) begin
      cnt_d = '0;
    end else if (d_gnt) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign starve = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch and data requesters, fixed data priority,
// 1-cycle pipelined reads. Define MEM_ARB_STARVE_EN to add the fetch anti-starvation override.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_AW     = MEM_AW_DEFAULT,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  logic  if_gnt;
  logic  d_gnt;
  logic  starve;
  rsel_t rsel_q, rsel_d;

`ifdef MEM_ARB_STARVE_EN
  mem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt),
    .starve (starve)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign starve = 1'b0;
`endif

  // Only the word-index bits of the byte addresses reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:MEM_AW+2], bus.if_addr[1:0],
                              bus.d_addr[31:MEM_AW+2], bus.d_addr[1:0]};

  // Return-owner register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsel_q <= NONE;
    end else begin
      rsel_q <= rsel_d;
    end
  end

  always_comb begin
    rsel_d = NONE;
    if (if_gnt) begin
      rsel_d = IF;
    end else if (d_gnt && !bus.d_we) begin
      rsel_d = D;
    end
  end

  // Grants are blanked during reset so nothing reaches the memory.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (bus.if_req && (!bus.d_req || starve)) begin
        if_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.m_en      = if_gnt | d_gnt;
    bus.m_we      = d_gnt & bus.d_we;
    bus.m_addr    = d_gnt ? bus.d_addr[MEM_AW+1:2] : bus.if_addr[MEM_AW+1:2];
    bus.m_wdata   = bus.d_wdata;
    bus.if_rvalid = (rsel_q == IF);
    bus.d_rvalid  = (rsel_q == D);
    bus.if_rdata  = (rsel_q == IF) ? bus.m_rdata : '0;
    bus.d_rdata   = (rsel_q == D) ? bus.m_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned SMAX  = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.MEM_AW(AW)) bus ();

  mem_port_arbiter #(
    .MEM_AW     (AW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the arbiter, plus a preload port used while in reset.
  logic [31:0]   mem [DEPTH];
  logic          pre_we;
  logic [AW-1:0] pre_idx;
  logic [31:0]   pre_data;

  always_ff @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (bus.m_en && bus.m_we) begin
      mem[bus.m_addr] <= bus.m_wdata;
    end else if (bus.m_en) begin
      bus.m_rdata <= mem[bus.m_addr];
    end
  end

  // Reference model state: memory image, consecutive fetch denials, pending return.
  logic [31:0] ref_mem [DEPTH];
  int          denied;
  int          pend_port;   // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check against the model, advance model on the clock edge.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dwd,
                      output logic g_if, output logic g_d);
    int idx;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    #1;
    g_if = ir && (!dr || (STARVE_EN && denied == int'(SMAX)));
    g_d  = dr && !g_if;
    idx  = g_d ? int'((da >> 2) % DEPTH) : int'((ia >> 2) % DEPTH);
    chk("if_gnt", 32'(bus.if_gnt), 32'(g_if));
    chk("d_gnt", 32'(bus.d_gnt), 32'(g_d));
    chk("m_en", 32'(bus.m_en), 32'(g_if || g_d));
    chk("m_we", 32'(bus.m_we), 32'(g_d && dwe));
    if (g_if || g_d) chk("m_addr", 32'(bus.m_addr), 32'(idx));
    if (g_d && dwe) chk("m_wdata", bus.m_wdata, dwd);
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(pend_port == 1));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(pend_port == 2));
    if (pend_port == 1) chk("if_rdata", bus.if_rdata, pend_data);
    if (pend_port == 2) chk("d_rdata", bus.d_rdata, pend_data);
    @(posedge clk);
    pend_port = 0;
    if (g_if) begin
      pend_port = 1;
      pend_data = ref_mem[idx];
    end else if (g_d && !dwe) begin
      pend_port = 2;
      pend_data = ref_mem[idx];
    end else if (g_d) begin
      ref_mem[idx] = dwd;
    end
    if (g_if || !ir) denied = 0;
    else if (g_d) denied++;
    @(negedge clk);
  endtask

  task automatic idle();
    logic a, b;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, a, b);
  endtask

  logic        gi, gd;
  logic        r_ir, r_dr, r_dwe;
  logic [31:0] r_ia, r_da, r_dwd;
  int          if_grants;

  initial begin
    checks = 0;
    errors = 0;
    denied = 0;
    pend_port = 0;
    pend_data = '0;
    rst = 1'b1;
    pre_we = 1'b0;
    pre_idx = '0;
    pre_data = '0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;

    // Preload memory while reset holds the arbiter idle.
    @(negedge clk);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rst_m_en", 32'(bus.m_en), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      pre_we   = 1'b1;
      pre_idx  = AW'(i);
      pre_data = (i == 2) ? 32'h0000_00AA : $urandom;
      ref_mem[i] = pre_data;
      @(negedge clk);
    end
    pre_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Fetch of word 2, returned next cycle.
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    idle();
    // Data write then read-back of 0x10.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h55, gi, gd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, gi, gd);
    idle();
    // Address wrap: 0x104 -> word 1.
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, gi, gd);
    idle();
    // Alternating fetch/data reads with no bubbles.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
      else step(1'b0, 32'h0, 1'b1, 1'b0, $urandom, 32'h0, gi, gd);
    end
    idle();

    // Both requesting continuously: count fetch grants over 15 cycles.
    if_grants = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, $urandom, 1'b1, 1'b0, $urandom, 32'h0, gi, gd);
      if (gi) if_grants++;
    end
    chk("starve_if_grants", 32'(bus.if_req), 32'd1);
    checks++;
    assert (if_grants == (STARVE_EN ? 3 : 0))
    else begin
      errors++;
      $error("FAIL starve_pattern observed=%0d expected=%0d", if_grants, STARVE_EN ? 3 : 0);
    end
    idle();
    idle();

    // Reset one cycle after a fetch grant: the read must not return.
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    rst = 1'b1;
    #1;
    chk("rst_async_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_async_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst_async_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst_async_m_en", 32'(bus.m_en), 32'd0);
    chk("rst_async_m_we", 32'(bus.m_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    rst = 1'b0;
    pend_port = 0;
    denied = 0;
    step(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    idle();

    // Random traffic; requests are held until granted.
    r_ir = 1'b0;
    r_dr = 1'b0;
    r_ia = '0;
    r_da = '0;
    r_dwe = 1'b0;
    r_dwd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!r_ir) begin
        r_ir = ($urandom_range(0, 3) != 0);
        r_ia = $urandom;
      end
      if (!r_dr) begin
        r_dr  = ($urandom_range(0, 3) != 0);
        r_da  = $urandom;
        r_dwe = $urandom_range(0, 1) == 1;
        r_dwd = $urandom;
      end
      step(r_ir, r_ia, r_dr, r_dwe, r_da, r_dwd, gi, gd);
      if (gi) r_ir = 1'b0;
      if (gd) r_dr = 1'b0;
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
